// File: rtl/sevenseg_pkg.sv
// Shared types and glyph table for the seven-segment scan driver.
//   glyph_t       : positive-logic segment pattern, bit k = segment k (0..6)
//   slot_state_t  : per-slot scan phase (anti-ghost blank, then drive)
//   hex_to_glyph  : nibble to glyph lookup
package sevenseg_pkg;

  typedef logic [6:0] glyph_t;

  typedef enum logic [0:0] {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_t;

  localparam glyph_t GLYPH_0   = 7'h3F;
  localparam glyph_t GLYPH_1   = 7'h06;
  localparam glyph_t GLYPH_2   = 7'h5B;
  localparam glyph_t GLYPH_3   = 7'h4F;
  localparam glyph_t GLYPH_4   = 7'h66;
  localparam glyph_t GLYPH_5   = 7'h6D;
  localparam glyph_t GLYPH_6   = 7'h7D;
  localparam glyph_t GLYPH_7   = 7'h07;
  localparam glyph_t GLYPH_8   = 7'h7F;
  localparam glyph_t GLYPH_9   = 7'h67;
  localparam glyph_t GLYPH_A   = 7'h77;
  localparam glyph_t GLYPH_B   = 7'h7C;
  localparam glyph_t GLYPH_C   = 7'h39;
  localparam glyph_t GLYPH_D   = 7'h5E;
  localparam glyph_t GLYPH_E   = 7'h79;
  localparam glyph_t GLYPH_F   = 7'h71;
  localparam glyph_t GLYPH_OFF = 7'h00;

  function automatic glyph_t hex_to_glyph(input logic [3:0] nibble);
    glyph_t g;
    g = GLYPH_OFF;
    case (nibble)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      4'hF: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sevenseg_glyph.sv
// Combinational hex nibble to seven-segment glyph decoder.
//   nibble : hex digit 0..F
//   glyph  : positive-logic segment pattern (bit k = segment k)
module sevenseg_glyph
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output glyph_t     glyph
);

  always_comb glyph = hex_to_glyph(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// Inputs are captured into a shadow set on load and promoted to the active
// set only at frame boundaries, so a frame never shows a mix of values.
//   clk, reset_n : clock, asynchronous active-low reset
//   value        : packed nibbles, digit k = value[4k+3:4k]
//   dp_mask      : decimal point on for digit k
//   blank_mask   : force digit k dark
//   lz_en        : leading-zero suppression enable
//   load         : single-cycle capture strobe
//   seg          : active-low segments, seg[7] = DP
//   dig_n        : active-low digit enable, one-cold or all high
//   frame_done   : one-cycle pulse at the first cycle of each frame
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_done
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx;

  logic [4*NUM_DIGITS-1:0] value_sh, value_act, value_src;
  logic [NUM_DIGITS-1:0]   dp_sh, dp_act, dp_src;
  logic [NUM_DIGITS-1:0]   blank_sh, blank_act, blank_src;
  logic                    lz_sh, lz_src;
  logic [NUM_DIGITS-1:0]   lz_mask_act;

  logic        slot_end, boundary;
  slot_state_t slot_state;
  logic [3:0]  nib;
  logic        dp_sel, dark_sel;
  logic [NUM_DIGITS-1:0] dig_sel;
  glyph_t      glyph;
  logic [7:0]  seg_c;
  logic [NUM_DIGITS-1:0] dig_n_c;

  // A digit is suppressed when it and every higher digit is a zero nibble
  // with no DP; the walk runs from the top digit down and stops at digit 1.
  function automatic logic [NUM_DIGITS-1:0] calc_lz_mask(
    input logic [4*NUM_DIGITS-1:0] v,
    input logic [NUM_DIGITS-1:0]   dp,
    input logic                    en
  );
    logic                  run;
    logic [NUM_DIGITS-1:0] m;
    m   = '0;
    run = en;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      run  = run && (v[4*k +: 4] == 4'h0) && !dp[k];
      m[k] = run;
    end
    return m;
  endfunction

  assign slot_end = (pre == PRE_W'(SCAN_DIV - 1));
  assign boundary = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  // A load in the boundary cycle bypasses shadow straight into the active set.
  always_comb begin
    value_src = load ? value      : value_sh;
    dp_src    = load ? dp_mask    : dp_sh;
    blank_src = load ? blank_mask : blank_sh;
    lz_src    = load ? lz_en      : lz_sh;
  end

  always_comb begin
    nib      = '0;
    dp_sel   = 1'b0;
    dark_sel = 1'b0;
    dig_sel  = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib        = value_act[4*k +: 4];
        dp_sel     = dp_act[k];
        dark_sel   = blank_act[k] | lz_mask_act[k];
        dig_sel[k] = 1'b0;
      end
    end
  end

  sevenseg_glyph u_glyph (
    .nibble (nib),
    .glyph  (glyph)
  );

  // Dark digits keep their enable asserted so every slot has equal duty.
  always_comb begin
    slot_state = (pre < PRE_W'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_DRIVE;
    seg_c      = 8'hFF;
    dig_n_c    = '1;
    if (slot_state == SLOT_DRIVE) begin
      dig_n_c = dig_sel;
      if (!dark_sel) seg_c = {~dp_sel, ~glyph};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre         <= '0;
      idx         <= '0;
      value_sh    <= '0;
      dp_sh       <= '0;
      blank_sh    <= '0;
      lz_sh       <= 1'b0;
      value_act   <= '0;
      dp_act      <= '0;
      blank_act   <= '0;
      lz_mask_act <= '0;
      seg         <= 8'hFF;
      dig_n       <= '1;
      frame_done  <= 1'b0;
    end else begin
      if (load) begin
        value_sh <= value;
        dp_sh    <= dp_mask;
        blank_sh <= blank_mask;
        lz_sh    <= lz_en;
      end
      if (boundary) begin
        value_act   <= value_src;
        dp_act      <= dp_src;
        blank_act   <= blank_src;
        lz_mask_act <= calc_lz_mask(value_src, dp_src, lz_src);
      end
      if (slot_end) begin
        pre <= '0;
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      seg        <= seg_c;
      dig_n      <= dig_n_c;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed self-checking bench for sevenseg_scan_driver with a 4-digit bank,
// 8-cycle slots and 2 blank cycles per slot.
module tb_sevenseg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   value;
  logic [3:0]    dp_mask;
  logic [3:0]    blank_mask;
  logic          lz_en;
  logic          load;
  logic [7:0]    seg;
  logic [3:0]    dig_n;
  logic          frame_done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0] cap_seg [ND];
  logic [3:0] cap_dig [ND];

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .load       (load),
    .seg        (seg),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Steps negedges until frame_done is seen; n is the number of steps taken.
  task automatic wait_fd(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) chk("fd_timeout", 32'd0, 32'd1);
  endtask

  // Called one cycle after frame_done; samples each digit at pre=4 of its slot.
  task automatic grab_frame();
    for (int unsigned d = 0; d < ND; d++) begin
      repeat ((d == 0) ? 4 : 8) @(negedge clk);
      cap_seg[d] = seg;
      cap_dig[d] = dig_n;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp,
                         input logic [3:0] bl, input logic lz);
    value      = v;
    dp_mask    = dp;
    blank_mask = bl;
    lz_en      = lz;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned ff_cnt;
    int unsigned en_cnt;

    reset_n    = 1'b0;
    value      = '0;
    dp_mask    = '0;
    blank_mask = '0;
    lz_en      = 1'b0;
    load       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg",   seg,        8'hFF);
    chk("rst_dig",   dig_n,      4'hF);
    chk("rst_fd",    frame_done, 1'b0);

    // Reset release and first drive
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre1_blank_seg", seg,   8'hFF);
    chk("pre1_blank_dig", dig_n, 4'hF);
    @(negedge clk);
    chk("first_drive_seg", seg,   8'hC0);
    chk("first_drive_dig", dig_n, 4'hE);
    wait_fd(n);
    chk("first_fd_delay", n, 32'd29);
    wait_fd(n);
    chk("frame_period", n, 32'd32);
    @(negedge clk);
    chk("fd_pulse_width", frame_done, 1'b0);
    chk("fd_blank_seg",   seg,        8'hFF);
    chk("fd_blank_dig",   dig_n,      4'hF);
    grab_frame();
    chk("rst_d0_seg", cap_seg[0], 8'hC0);
    chk("rst_d0_dig", cap_dig[0], 4'hE);
    chk("rst_d1_dig", cap_dig[1], 4'hD);
    chk("rst_d2_dig", cap_dig[2], 4'hB);
    chk("rst_d3_dig", cap_dig[3], 4'h7);

    // Value A: 12AF, DP on digit 2, no suppression
    wait_fd(n);
    repeat (10) @(negedge clk);
    do_load(16'h12AF, 4'b0100, 4'b0000, 1'b0);
    wait_fd(n);
    chk("a_fd_delay", n, 32'd21);
    @(negedge clk);
    grab_frame();
    chk("a_d0", cap_seg[0], 8'h8E);
    chk("a_d1", cap_seg[1], 8'h88);
    chk("a_d2", cap_seg[2], 8'h24);
    chk("a_d3", cap_seg[3], 8'hF9);

    // Value B loaded mid-frame: rest of this frame stays A
    wait_fd(n);
    repeat (3) @(negedge clk);
    do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
    repeat (9) @(negedge clk);
    chk("b_old_d1", seg, 8'h88);
    repeat (8) @(negedge clk);
    chk("b_old_d2", seg, 8'h24);
    wait_fd(n);
    @(negedge clk);
    grab_frame();
    chk("b_d0", cap_seg[0], 8'hC0);
    chk("b_d1", cap_seg[1], 8'h92);
    chk("b_d2", cap_seg[2], 8'hFF);
    chk("b_d3", cap_seg[3], 8'hFF);
    chk("b_d3_dig", cap_dig[3], 4'h7);

    // Value C: DP on digit 2 stops suppression there; loaded late in frame
    do_load(16'h0050, 4'b0100, 4'b0000, 1'b1);
    wait_fd(n);
    @(negedge clk);
    grab_frame();
    chk("c_d0", cap_seg[0], 8'hC0);
    chk("c_d1", cap_seg[1], 8'h92);
    chk("c_d2", cap_seg[2], 8'h40);
    chk("c_d3", cap_seg[3], 8'hFF);

    // Value D loaded exactly in the boundary cycle
    wait_fd(n);
    repeat (31) @(negedge clk);
    do_load(16'hB3D9, 4'b0001, 4'b0000, 1'b0);
    chk("bnd_fd", frame_done, 1'b1);
    @(negedge clk);
    grab_frame();
    chk("d_d0", cap_seg[0], 8'h18);
    chk("d_d1", cap_seg[1], 8'hA1);
    chk("d_d2", cap_seg[2], 8'hB0);
    chk("d_d3", cap_seg[3], 8'h83);
    wait_fd(n);
    @(negedge clk);
    grab_frame();
    chk("d_persist_d2", cap_seg[2], 8'hB0);

    // Blank mask on digit 1 for its whole slot
    do_load(16'hB3D9, 4'b0001, 4'b0010, 1'b0);
    wait_fd(n);
    repeat (8) @(negedge clk);
    ff_cnt = 0;
    en_cnt = 0;
    for (int unsigned i = 0; i < SD; i++) begin
      @(negedge clk);
      if (seg == 8'hFF) ff_cnt++;
      if (dig_n == 4'hD) en_cnt++;
    end
    chk("blank_slot_ff", ff_cnt, SD);
    chk("blank_slot_en", en_cnt, SD - BC);
    repeat (5) @(negedge clk);
    chk("blank_nbr_d2", seg, 8'hB0);

    // Asynchronous reset in the middle of a drive phase
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_seg", seg,        8'hFF);
    chk("async_rst_dig", dig_n,      4'hF);
    chk("async_rst_fd",  frame_done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rescan_seg", seg,   8'hC0);
    chk("rescan_dig", dig_n, 4'hE);
    wait_fd(n);
    chk("rescan_fd_delay", n, 32'd29);
    @(negedge clk);
    grab_frame();
    chk("rescan_shadow_cleared", cap_seg[0], 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
